pwm_fader: RTL and testbench
============================

PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 Parameter N, default 8: width of duty; must match downstream pwm N.
REQ-002 Parameter PW, default 16: width of prescaler rate.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset is asynchronous and active-low (rst=0 resets).
REQ-005 Port ena, input, 1: enables the prescaler; ena=0 freezes prescaler, FSM, hold counter and duty.
REQ-006 Port start, input, 1: single-cycle request to begin a fade; ignored unless state=IDLE.
REQ-007 Port stop, input, 1: synchronous abort; takes effect in any state.
REQ-008 Port loop, input, 1: sampled on accepted start; 1 means repeat fades continuously, 0 means single-shot.
REQ-009 Port rate, input, PW: step period minus 1, in clk cycles; used live.
REQ-010 Port hold, input, N: dwell at each extreme, in steps minus 1; sampled on accepted start.
REQ-011 Port step, output, 1: registered one-cycle strobe that drives pwm step.
REQ-012 Port duty, output, N: registered duty value that drives pwm duty.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.
REQ-014 Port done, output, 1: registered one-cycle pulse at the end of a single-shot fade.

Function
REQ-015 The prescaler counter pcnt SHALL advance as follows when ena=1:
- Internal tick = (pcnt >= rate).
- On tick, pcnt <= 0; otherwise pcnt <= pcnt+1.
- rate=0 gives a tick every cycle.
- Reducing rate below pcnt gives a tick on the next cycle.
REQ-016 When ena=0, pcnt SHALL hold and tick SHALL be 0.
REQ-017 step SHALL equal the tick registered by one cycle. duty updates on the same edge, so a new duty and its step strobe appear in the same cycle.
REQ-018 The FSM SHALL have the states IDLE, UP, HOLD_HI, DOWN and HOLD_LO (MAX = 2^N-1).
REQ-019 IDLE: duty=0; start=1 with stop=0 -> UP next cycle; loop and hold are latched at that edge.
REQ-020 UP, on tick: if duty==MAX -> HOLD_HI with hcnt<=0; otherwise duty<=duty+1.
REQ-021 HOLD_HI, on tick: if hcnt==hold_q -> DOWN; otherwise hcnt<=hcnt+1. duty holds at MAX.
REQ-022 DOWN, on tick: if duty==0 -> HOLD_LO with hcnt<=0; otherwise duty<=duty-1.
REQ-023 HOLD_LO, on tick: if hcnt==hold_q then go to UP when loop_q=1, or to IDLE with done=1 the next cycle when loop_q=0; otherwise hcnt<=hcnt+1.
REQ-024 duty SHALL never wrap: no increment above MAX, no decrement below 0.
REQ-025 stop=1 SHALL force IDLE, duty<=0 and hcnt<=0 on the next edge, with no done pulse. stop wins over a simultaneous start or tick.
REQ-026 The state SHALL change only on tick, except for the start and stop transitions.
REQ-027 A single-shot fade SHALL take 2*(MAX+1) + 2*(hold+1) ticks, counted from entry to UP until IDLE.

Reset
REQ-028 While rst=0: pcnt=0, hcnt=0, state=IDLE, duty=0, step=0, busy=0, done=0, loop_q=0, hold_q=0.
REQ-029 Reset mid-fade SHALL abandon the fade immediately, asynchronously; no done pulse on release.
REQ-030 The first tick after rst rises SHALL occur rate+1 enabled cycles later.

Structure
REQ-031 Package pwm_fader_pkg SHALL hold the enum fader_state_t, with encodings IDLE=0 and the others in declaration order.
REQ-032 The prescaler SHALL be a separate sub-module, tick_gen, with ports clk, rst, ena, rate and tick.
REQ-033 The FSM, hold counter and duty registers SHALL live in pwm_fader; no latches.

Verification
REQ-034 N=4, rate=0, hold=1, loop=0, pulse start: duty goes 0..15, holds 15 for 2 steps, goes 15..0, holds 0 for 2 steps; done is high 1 cycle, 36 ticks after UP entry.
REQ-035 rate=3, ena=1: step is high exactly 1 of every 4 cycles; ena=0 for 10 cycles mid-fade leaves duty, step=0 and the cadence resumes unchanged.
REQ-036 loop=1, N=4, hold=0: after HOLD_LO, state returns to UP; busy stays high and done never pulses across 3 fades.
REQ-037 stop asserted with duty=9 in DOWN, same cycle as a tick: next cycle state=IDLE, duty=0, done=0; start and stop together in IDLE leave state IDLE.
REQ-038 rst=0 asserted asynchronously mid-UP between clock edges: outputs go to zero without a clock edge; after release with rate=2, the first step appears on the 3rd enabled cycle.
REQ-039 start pulsed while busy: hold and loop changes are ignored and the fade sequence is unchanged.

Source files
------------

// File: rtl/pwm_fader_pkg.sv
// Shared types for the PWM fader: FSM state encoding.
package pwm_fader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } fader_state_t;

endpackage

// File: rtl/pwm_fader_tick_gen.sv
// Prescaler: emits a one-cycle tick every rate+1 enabled cycles.
// rate is used live; lowering it below the running count ticks at once.
module tick_gen #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] rate,
  output logic          tick
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = ena && (pcnt_q >= rate);

  // Next count: wrap on tick, otherwise advance; frozen while disabled.
  always_comb begin
    pcnt_d = pcnt_q;
    if (ena) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt_q <= '0;
    else      pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pwm_fader.sv
// PWM fader: ramps duty 0..MAX, dwells, ramps back to 0, dwells, then
// finishes (single-shot) or repeats (loop). One duty change per tick.
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [PW-1:0] rate,
  input  logic [N-1:0]  hold,
  output logic          step,
  output logic [N-1:0]  duty,
  output logic          busy,
  output logic          done
);

  localparam logic [N-1:0] MAX = '1;

  logic tick;

  fader_state_t state_q, state_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] hcnt_q, hcnt_d;
  logic [N-1:0] hold_q, hold_d;
  logic         loop_q, loop_d;
  logic         done_q, done_d;
  logic         step_q;

  tick_gen #(.PW(PW)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .rate (rate),
    .tick (tick)
  );

  // Next-state logic: stop overrides everything; other moves happen on tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hcnt_d  = hcnt_q;
    hold_d  = hold_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      duty_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d = '0;
          if (start) begin
            state_d = UP;
            hold_d  = hold;
            loop_d  = loop;
          end
        end
        UP: begin
          if (tick) begin
            if (duty_q == MAX) begin
              state_d = HOLD_HI;
              hcnt_d  = '0;
            end else begin
              duty_d = duty_q + N'(1);
            end
          end
        end
        HOLD_HI: begin
          if (tick) begin
            if (hcnt_q == hold_q) state_d = DOWN;
            else                  hcnt_d  = hcnt_q + N'(1);
          end
        end
        DOWN: begin
          if (tick) begin
            if (duty_q == '0) begin
              state_d = HOLD_LO;
              hcnt_d  = '0;
            end else begin
              duty_d = duty_q - N'(1);
            end
          end
        end
        HOLD_LO: begin
          if (tick) begin
            if (hcnt_q == hold_q) begin
              if (loop_q) begin
                state_d = UP;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              hcnt_d = hcnt_q + N'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // State, counters and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hcnt_q  <= '0;
      hold_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hcnt_q  <= hcnt_d;
      hold_q  <= hold_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      step_q  <= tick;
    end
  end

  assign step = step_q;
  assign duty = duty_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_fader.sv
// Testbench for pwm_fader (N=4). The reference model describes a fade as
// a closed-form duty profile over "ticks since UP entry".
module tb_pwm_fader;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 8;
  localparam int          M  = (1 << N) - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          ena   = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic          loop  = 1'b0;
  logic [PW-1:0] rate  = '0;
  logic [N-1:0]  hold  = '0;
  logic          step, busy, done;
  logic [N-1:0]  duty;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ecnt   = 0;   // enabled cycles since reset
  int k      = 0;   // ticks since entry to UP
  int hm     = 0;   // latched hold
  bit active = 0;
  bit lpm    = 0;
  bit exp_step = 0;
  bit exp_done = 0;

  pwm_fader #(.N(N), .PW(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (start),
    .stop  (stop),
    .loop  (loop),
    .rate  (rate),
    .hold  (hold),
    .step  (step),
    .duty  (duty),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic int fade_len(int h);
    return 2 * (M + 1) + 2 * (h + 1);
  endfunction

  function automatic int duty_of(int kk, int h);
    int d0;
    d0 = M + h + 2;
    if (kk <= M)      return kk;
    if (kk < d0)      return M;
    if (kk <= d0 + M) return M - (kk - d0);
    return 0;
  endfunction

  function automatic logic [N+2:0] exp_vec();
    return {exp_step, active, exp_done, N'(active ? duty_of(k, hm) : 0)};
  endfunction

  // One clock edge: advance the model from the inputs seen at the edge.
  task automatic clk_edge();
    bit tk;
    @(posedge clk);
    tk = ena && ((ecnt % (int'(rate) + 1)) == int'(rate));
    if (ena) ecnt++;
    exp_step = tk;
    exp_done = 0;
    if (stop) begin
      active = 0;
      k      = 0;
    end else if (!active) begin
      if (start) begin
        active = 1;
        k      = 0;
        hm     = int'(hold);
        lpm    = loop;
      end
    end else if (tk) begin
      k++;
      if (k == fade_len(hm)) begin
        k = 0;
        if (!lpm) begin
          active   = 0;
          exp_done = 1;
        end
      end
    end
    #1;
  endtask

  task automatic model_reset();
    ecnt = 0; k = 0; hm = 0; active = 0; lpm = 0; exp_step = 0; exp_done = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({step, busy, done, duty} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", {step, busy, done, duty}, 7'b0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({step, busy, done, duty} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", {step, busy, done, duty}, 7'b0);
    end
    start = 1'b0;
    apply_reset();
  endtask

  task automatic test_single_shot();
    int ticks, done_cnt, done_at;
    rate = '0; hold = 4'd1; loop = 1'b0; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    ticks = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 45; i++) begin
      clk_edge();
      if (step) ticks++;
      if (done) begin done_cnt++; done_at = ticks; end
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL single_shot cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 36) begin
      errors++;
      $display("FAIL single_shot_done: got count %0d at tick %0d expected 1 at 36", done_cnt, done_at);
    end
  endtask

  task automatic test_cadence_ena();
    int nsteps;
    rate = 8'd3; hold = N'($urandom_range(0, 3)); loop = 1'b1; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 70; i++) begin
      ena = (i >= 40 && i < 50) ? 1'b0 : 1'b1;
      clk_edge();
      start = 1'b0;
      if (i < 40 && step) nsteps++;
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL cadence cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    checks++;
    if (nsteps != 10) begin
      errors++;
      $display("FAIL cadence_count: got %0d steps expected 10", nsteps);
    end
    ena = 1'b1; stop = 1'b1;
    clk_edge();
    stop = 1'b0;
  endtask

  task automatic test_loop();
    int done_cnt, idle_cnt;
    rate = '0; hold = '0; loop = 1'b1; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    done_cnt = 0; idle_cnt = 0;
    for (int i = 0; i < 3 * fade_len(0) + 5; i++) begin
      clk_edge();
      if (done) done_cnt++;
      if (!busy) idle_cnt++;
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL loop cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    checks++;
    if (done_cnt != 0 || idle_cnt != 0) begin
      errors++;
      $display("FAIL loop_busy: got done %0d idle %0d expected 0 0", done_cnt, idle_cnt);
    end
    stop = 1'b1;
    clk_edge();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    bit found;
    rate = '0; hold = N'($urandom_range(0, 3)); loop = 1'b0; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      clk_edge();
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL stop_run cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
      if (active && k == M + hm + 2 + 6) found = 1;
    end
    checks++;
    if (!found || duty !== N'(9)) begin
      errors++;
      $display("FAIL stop_reach: got found %0d duty %0d expected found 1 duty 9", found, duty);
    end
    stop = 1'b1;
    clk_edge();
    stop = 1'b0;
    checks++;
    if ({busy, done, duty} !== '0 || {step, busy, done, duty} !== exp_vec()) begin
      errors++;
      $display("FAIL stop_abort: got %b expected %b", {step, busy, done, duty}, exp_vec());
    end
    start = 1'b1; stop = 1'b1;
    clk_edge();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || {step, busy, done, duty} !== exp_vec()) begin
      errors++;
      $display("FAIL stop_start_same: got %b expected %b", {step, busy, done, duty}, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int first;
    rate = '0; hold = 4'd2; loop = 1'b0; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk_edge();
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL areset_pre cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({step, busy, done, duty} !== '0) begin
      errors++;
      $display("FAIL areset_nolk: got %b expected %b", {step, busy, done, duty}, 7'b0);
    end
    model_reset();
    rate = 8'd2;
    @(posedge clk); #3;
    rst = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      clk_edge();
      if (step && first == 0) first = i;
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL areset_post cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL areset_first_step: got cycle %0d expected 3", first);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt, ticks, n;
    rate = 8'd1; hold = 4'd2; loop = 1'b0; ena = 1'b1;
    apply_reset();
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    done_cnt = 0; ticks = 0; n = 0;
    while ((busy || n < 5) && n < 400) begin
      if (n == 20) begin start = 1'b1; hold = '0; loop = 1'b1; end
      clk_edge();
      start = 1'b0;
      n++;
      if (step && busy) ticks++;
      if (done) begin done_cnt++; ticks++; end
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %b expected %b", n, {step, busy, done, duty}, exp_vec());
      end
    end
    checks++;
    if (done_cnt != 1 || ticks != fade_len(2)) begin
      errors++;
      $display("FAIL b2b_len: got done %0d ticks %0d expected 1 %0d", done_cnt, ticks, fade_len(2));
    end
  endtask

  task automatic test_random();
    rate = PW'($urandom_range(0, 3)); loop = 1'b0; ena = 1'b1;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      ena   = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      loop  = ($urandom_range(0, 3) == 0);
      hold  = N'($urandom_range(0, 3));
      clk_edge();
      checks++;
      if ({step, busy, done, duty} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", i, {step, busy, done, duty}, exp_vec());
      end
    end
    start = 1'b0; stop = 1'b0; ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_cadence_ena();
    test_loop();
    test_stop();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
